// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier
// Multi-cycle radix-4 Booth multiplier with a start/done handshake, for
// signed and unsigned operands. A single accumulator adder is reused over
// N/2+1 iterations. The accumulator/multiplier pair shifts right by two
// bits each iteration, and the product is read from it at the end.
//
// Optional build macro: MULT_ZERO_BYPASS_EN
//   When defined, a zero operand skips RUN and the result is presented one
//   cycle after acceptance.
//   When undefined, latency is N/2+1 cycles for every input.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands are latched when start is accepted
// RUN   | one Booth digit per cycle; the final iteration writes P and
//       | pulses done

module seq_booth_multiplier #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   P
);

    // The multiplicand and multiplier are extended to W bits. The
    // accumulator carries two further guard bits. The running partial sum,
    // after its shifts, can reach about 8/3 of |M|. Without the guard bits
    // that value would overflow at the -2^(N-1) squared corner.
    localparam int W     = N + 2;
    localparam int ACC_W = N + 4;
    localparam int LAST  = N / 2;
    localparam int CNT_W = $clog2(LAST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]      m_q;
    logic [W:0]        q_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*N-1:0]    p_q;
    logic              done_q;

    logic              accept;
    logic              step;
    logic              last_iter;
    logic              finish;
    logic              zero_result;

    logic [W-1:0]      a_ext;
    logic [W-1:0]      b_ext;

    logic              neg;
    logic [1:0]        mag;
    logic [ACC_W-1:0]  m_ext;
    logic [ACC_W-1:0]  operand;
    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W+W:0]  shifted;
    logic [ACC_W-1:0]  acc_nxt;
    logic [W:0]        q_nxt;
    logic [2*N-1:0]    product_lo;

`ifdef MULT_ZERO_BYPASS_EN
    logic              zero_q;
`endif

    assign a_ext = {{2{is_signed & A[N-1]}}, A};
    assign b_ext = {{2{is_signed & B[N-1]}}, B};

    assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(LAST));

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_result = (state_q == RUN) && zero_q;
`else
    assign zero_result = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the controls for loading and stepping the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_iter || zero_result) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Radix-4 Booth recoding of the three low bits of the multiplier window.
    always_comb begin
        neg = 1'b0;
        mag = 2'd0;
        case (q_q[2:0])
            3'b001, 3'b010: begin neg = 1'b0; mag = 2'd1; end
            3'b011:         begin neg = 1'b0; mag = 2'd2; end
            3'b100:         begin neg = 1'b1; mag = 2'd2; end
            3'b101, 3'b110: begin neg = 1'b1; mag = 2'd1; end
            default:        begin neg = 1'b0; mag = 2'd0; end
        endcase
    end

    // Select the multiple, add it to the accumulator, and shift the pair
    // right by two bits.
    always_comb begin
        m_ext = {{(ACC_W-W){m_q[W-1]}}, m_q};
        case (mag)
            2'd1:    operand = m_ext;
            2'd2:    operand = {m_ext[ACC_W-2:0], 1'b0};
            default: operand = '0;
        endcase
        addend     = neg ? ~operand : operand;
        acc_sum    = acc_q + addend + {{(ACC_W-1){1'b0}}, neg};
        shifted    = {{2{acc_sum[ACC_W-1]}}, acc_sum, q_q[W:2]};
        acc_nxt    = shifted[ACC_W+W:W+1];
        q_nxt      = shifted[W:0];
        product_lo = {acc_nxt[N-3:0], q_nxt[W:1]};
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            q_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            m_q   <= a_ext;
            q_q   <= {b_ext, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= acc_nxt;
            q_q   <= q_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef MULT_ZERO_BYPASS_EN
    // The zero-operand flag is captured with the operands so that later
    // changes on A and B cannot affect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= (A == '0) || (B == '0);
        end
    end
`endif

    // Result register and the one-cycle done pulse. P is written only on
    // completion, so a partial product is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                p_q <= zero_result ? '0 : product_lo;
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign P    = p_q;

endmodule
